// File: rtl/dom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : dom_pkg                                                      |
// | Description : Shared constants and state encoding for the masked GF(2^2)   |
// |               multiplier scheduler and its round-robin arbiter.            |
// | Contents    : GF2_W  - width of one GF(2^2) share                          |
// |               RND_W  - width of one randomness word (Z0 and Z1)            |
// |               PHASE1/PHASE2 - values of the mirrored multiplier phase      |
// |               state_t - scheduler operation states                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package dom_pkg;

  localparam int GF2_W = 2;
  localparam int RND_W = 4;

  // A phase value of 0 means the multiplier is in PHASE1 during this cycle.
  localparam logic PHASE1 = 1'b0;
  localparam logic PHASE2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                   |
// | Description : Combinational round-robin arbiter. The search starts one     |
// |               position after ptr and wraps, so the last winner gets the    |
// |               lowest priority next time.                                   |
// | Ports       : req   [N_REQ] in  - request vector                           |
// |               ptr   [IDW]   in  - index of the previous winner             |
// |               grant [N_REQ] out - one-hot winner                           |
// |               idx   [IDW]   out - winner index                             |
// |               found         out - at least one request present             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx,
  output logic             found
);

  logic [IDW-1:0] w_cand;

  always_comb begin
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    w_cand = '0;
    // k runs 1..N_REQ so the previous winner itself is examined last.
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDW'((int'(ptr) + k) % N_REQ);
      if (!found && req[w_cand]) begin
        found         = 1'b1;
        idx           = w_cand;
        grant[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dep_mult_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dep_mult_scheduler                                           |
// | Description : Shares one two-phase masked GF(2^2) multiplier among N_REQ   |
// |               requesters. Operations start only in the cycle before the    |
// |               multiplier enters PHASE1, carry a fresh (Z0, Z1) pair, and   |
// |               return the product shares through a valid/ready response.   |
// | Ports       : clk, reset (async, active-low)                               |
// |               req_valid/req_ready, req_ax/ay/bx/by  - requester side       |
// |               rnd_valid/rnd_ready, rnd_data         - randomness source    |
// |               mult_ax/ay/bx/by/z0/z1 out, mult_aq/bq in - multiplier side  |
// |               rsp_valid/rsp_ready, rsp_id, rsp_aq/bq - response side       |
// |               busy - any state other than IDLE                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dep_mult_scheduler
  import dom_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [GF2_W*N_REQ-1:0]   req_ax,
  input  logic [GF2_W*N_REQ-1:0]   req_ay,
  input  logic [GF2_W*N_REQ-1:0]   req_bx,
  input  logic [GF2_W*N_REQ-1:0]   req_by,
  input  logic                     rnd_valid,
  input  logic [RND_W-1:0]         rnd_data,
  output logic                     rnd_ready,
  output logic [GF2_W-1:0]         mult_ax,
  output logic [GF2_W-1:0]         mult_ay,
  output logic [GF2_W-1:0]         mult_bx,
  output logic [GF2_W-1:0]         mult_by,
  output logic [GF2_W-1:0]         mult_z0,
  output logic [GF2_W-1:0]         mult_z1,
  input  logic [GF2_W-1:0]         mult_aq,
  input  logic [GF2_W-1:0]         mult_bq,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [GF2_W-1:0]         rsp_aq,
  output logic [GF2_W-1:0]         rsp_bq,
  output logic                     busy
);

  state_t           r_state;
  logic             r_ph;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_cur_id;

  logic [N_REQ-1:0] w_arb_grant;
  logic [IDW-1:0]   w_arb_idx;
  logic             w_arb_found;
  logic             w_slot;
  logic             w_grant;
  logic [GF2_W-1:0] w_sel_ax, w_sel_ay, w_sel_bx, w_sel_by;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (r_rr_ptr),
    .grant (w_arb_grant),
    .idx   (w_arb_idx),
    .found (w_arb_found)
  );

  // Arbitrate only in a PHASE2 cycle so the operands land exactly when the
  // multiplier enters PHASE1; RESP may overlap with the next grant.
  assign w_slot    = (r_ph == PHASE2) &&
                     ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
  assign w_grant   = w_slot && w_arb_found && rnd_valid;
  assign req_ready = w_grant ? w_arb_grant : '0;
  assign rnd_ready = w_grant;
  assign busy      = (r_state != IDLE);

  always_comb begin
    w_sel_ax = '0;
    w_sel_ay = '0;
    w_sel_bx = '0;
    w_sel_by = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_idx == IDW'(i)) begin
        w_sel_ax = req_ax[GF2_W*i +: GF2_W];
        w_sel_ay = req_ay[GF2_W*i +: GF2_W];
        w_sel_bx = req_bx[GF2_W*i +: GF2_W];
        w_sel_by = req_by[GF2_W*i +: GF2_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ph      <= PHASE1;
      r_rr_ptr  <= IDW'(N_REQ - 1);
      r_cur_id  <= '0;
      mult_ax   <= '0;
      mult_ay   <= '0;
      mult_bx   <= '0;
      mult_by   <= '0;
      mult_z0   <= '0;
      mult_z1   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_aq    <= '0;
      rsp_bq    <= '0;
    end else begin
      r_ph <= ~r_ph;

      case (r_state)
        IDLE: begin
          if (w_grant) r_state <= P1;
        end
        P1: begin
          r_state <= P2;
        end
        P2: begin
          // Scrub shares and randomness as soon as the multiplier is done
          // with them so nothing lingers on the bus between operations.
          mult_ax <= '0;
          mult_ay <= '0;
          mult_bx <= '0;
          mult_by <= '0;
          mult_z0 <= '0;
          mult_z1 <= '0;
          r_state <= CAP;
        end
        CAP: begin
          rsp_aq    <= mult_aq;
          rsp_bq    <= mult_bq;
          rsp_id    <= r_cur_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_aq    <= '0;
            rsp_bq    <= '0;
            r_state   <= w_grant ? P1 : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_grant) begin
        mult_ax  <= w_sel_ax;
        mult_ay  <= w_sel_ay;
        mult_bx  <= w_sel_bx;
        mult_by  <= w_sel_by;
        mult_z0  <= rnd_data[GF2_W-1:0];
        mult_z1  <= rnd_data[2*GF2_W-1:GF2_W];
        r_rr_ptr <= w_arb_idx;
        r_cur_id <= w_arb_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/dep_mult_scheduler.md
Name: dep_mult_scheduler

Overview:
Round-robin scheduler that shares one two-phase masked GF(2^2) multiplier (DepMultiplier) among N_REQ requesters. It aligns each operation to the multiplier's free-running PHASE1/PHASE2 toggle, attaches fresh randomness (Z0, Z1) per operation, and returns the masked product shares with a valid/ready response. It sits between S-box/inversion sequencers and the single shared multiplier instance.

Parameters:
N_REQ, 4, number of requesters (2..8); IDW = clog2(N_REQ) is a derived localparam.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low (reset==0 clears all state)
req_valid  in  N_REQ  per-requester request
req_ready  out  N_REQ  one-hot accept pulse, same cycle as acceptance
req_ax, req_ay, req_bx, req_by  in  2*N_REQ each  share operands; slice i belongs to requester i
rnd_valid  in  1  fresh randomness available
rnd_data  in  4  Z0=rnd_data[1:0], Z1=rnd_data[3:2]
rnd_ready  out  1  randomness consumed this cycle
mult_ax, mult_ay, mult_bx, mult_by, mult_z0, mult_z1  out  2 each  registered drive to multiplier
mult_aq, mult_bq  in  2 each  multiplier result shares
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_id  out  IDW  requester index of response
rsp_aq, rsp_bq  out  2 each  result shares
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE, ph=0, rr_ptr=N_REQ-1, all mult_* =0, rsp_valid=0, rsp_id=0, rsp_aq/bq=0. req_ready=0, rnd_ready=0. Multiplier reset is tied to ~reset at integration so it enters PHASE1 together with ph=0.
- ph: mirror of the multiplier phase; toggles every cycle out of reset. ph==0 means the multiplier is in PHASE1 this cycle.
- Arbitration (cycle with ph==1, in IDLE, or in RESP with rsp_ready==1):
  - Winner is the first i with req_valid[i]=1, searching from rr_ptr+1 with wrap.
  - Grant requires rnd_valid=1. If rnd_valid=0, no grant, no req_ready, no rnd_ready, retry at next ph==1.
  - On grant: req_ready[w]=1 and rnd_ready=1 combinationally. Operands and rnd_data are registered into mult_* at the edge. rr_ptr<=w. Go to P1.
- P1 (ph=0): operands and Z presented; multiplier latches phase-1 terms. Go to P2.
- P2 (ph=1): operands held. mult_z0/mult_z1 are cleared to 0 at the end of this cycle, as are all other mult_* operands. Go to CAP.
- CAP (ph=0): rsp_aq<=mult_aq, rsp_bq<=mult_bq, rsp_id<=w, rsp_valid<=1. Go to RESP.
- RESP: rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid<=0, rsp_aq/bq<=0.
  - If ph==1 in that cycle, a new arbitration may grant in the same cycle; otherwise go to IDLE.
- Latency: accept at cycle t leads to rsp_valid at t+4. Peak throughput is one operation per 4 cycles.
- Operands are 0 whenever no operation is in P1/P2; shares of different requesters are never mixed, and each Z pair is used for exactly one operation.
- req_valid seen when ph==0 waits for the next cycle (no same-cycle grant). A requester must hold req_valid and its operands stable until req_ready.
- Reset mid-operation: everything is cleared immediately; the in-flight op is dropped with no response, and the requester must reissue.
- Simultaneous requests: only one grant per arbitration; losers keep req_ready=0.

Decomposition:
- Shared package dom_pkg: state encoding (IDLE, P1, P2, CAP, RESP), PHASE1/PHASE2 constants, GF2_W=2, RND_W=4.
- One natural sub-module: rr_arbiter (N_REQ-wide, pointer input, one-hot grant plus index output).
- The multiplier itself is instantiated at the top level, not inside this block.

Test Plan:
- Single request: req0 with Ax=2, Bx=0, Ay=2, By=0 and rnd=4'b0110, granted at a ph==1 cycle. Expect rsp_valid 4 cycles later, rsp_id=0, rsp_aq^rsp_bq=3, and mult_z0=2, mult_z1=1 during P1.
- Contention: req0..req3 all valid continuously with rsp_ready=1. Expect grants in order 0,1,2,3,0 every 4 cycles, with one-hot req_ready each time.
- Randomness stall: rnd_valid=0 for 6 cycles with req1 pending. Expect no grant and rnd_ready=0; grant occurs at the first ph==1 cycle after rnd_valid=1.
- Backpressure: rsp_ready=0 for 5 cycles. Expect rsp_* stable and no new grant; after rsp_ready=1, next grant no earlier than the same cycle if ph==1.
- Reset mid-op: assert reset in P2. Expect all outputs 0 and ph=0 asynchronously, no rsp_valid afterwards, and a fresh request served normally.
- Alignment: req arriving at a ph==0 cycle. Expect grant 1 cycle later; randomized shares always satisfy rsp_aq^rsp_bq = (Ax^Bx)·(Ay^By) in GF(4) with x^2+x+1.
